branch_predictor_btb: RTL and testbench

- Parametrised successor to the single-cycle branch-taken logic.
- A direct-mapped branch target buffer (BTB) with per-entry saturating direction counters gives a fetch-stage prediction (taken, target) every cycle.
- The block learns from branch/jump resolution in EX and flags mispredictions, with the correct redirect PC, back to the PC mux.
- Covers B-type (1100011), JAL (1101111) and JALR (1100111).

---
 rtl/branch_predictor_btb.sv | 187 ++++++++++++++++++
 tb/tb_branch_predictor_btb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters. It gives a fetch-stage prediction (taken, target) every cycle,
//   learns from EX-stage resolution of B-type, JAL and JALR instructions, and
//   flags mispredictions together with the correct redirect PC.
//
// Ports
//   clk_i                 clock
//   rst_i                 synchronous active-high reset
//   F_Pc_i                fetch PC being looked up
//   pred_taken_o          prediction for F_Pc_i: taken
//   pred_target_o         predicted target (0 when not taken)
//   flush_i               invalidate all entries (fence.i)
//   resolve_valid_i       an EX-stage control-flow instruction resolves
//   resolve_opcode_i      opcode of the resolving instruction
//   resolve_pc_i          its PC
//   resolve_taken_i       actual direction (1 for JAL/JALR)
//   resolve_target_i      actual target
//   resolve_pred_taken_i  prediction carried down the pipe
//   resolve_pred_target_i predicted target carried down the pipe
//   mispredict_o          redirect required this cycle
//   redirect_pc_o         correct next PC when mispredict_o = 1, else 0
//   perf_resolved_o       (BRANCH_PERF_CNT_EN) accepted resolve count
//   perf_mispredict_o     (BRANCH_PERF_CNT_EN) mispredict cycle count
//
// Optional feature macro: BRANCH_PERF_CNT_EN adds the two free-running
// performance counters above (cleared by rst_i only).

module branch_predictor_btb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CNT_BITS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] F_Pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            flush_i,
  input  logic            resolve_valid_i,
  input  logic [6:0]      resolve_opcode_i,
  input  logic [XLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  input  logic [XLEN-1:0] resolve_target_i,
  input  logic            resolve_pred_taken_i,
  input  logic [XLEN-1:0] resolve_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_resolved_o,
  output logic [31:0]     perf_mispredict_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1 << (CNT_BITS - 1));

  typedef enum logic [6:0] {
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } cf_opcode_e;

  // BTB storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q   [ENTRIES];

  // Low PC bits are always zero for aligned instructions and are not needed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_Pc_i[1:0], resolve_pc_i[1:0]};

  // ---------------------------------------------------------------------------
  // Fetch-side lookup (purely from state; no bypass of same-cycle updates)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = F_Pc_i[IDX_W+1:2];
  assign f_tag = F_Pc_i[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_taken_o  = f_hit && cnt_q[f_idx][CNT_BITS-1];
  assign pred_target_o = pred_taken_o ? target_q[f_idx] : '0;

  // ---------------------------------------------------------------------------
  // Resolve-side decode and mispredict detection
  // ---------------------------------------------------------------------------
  logic             is_branch;
  logic             is_jump;
  logic             accept;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  assign is_branch = (resolve_opcode_i == OP_BRANCH);
  assign is_jump   = (resolve_opcode_i == OP_JAL) || (resolve_opcode_i == OP_JALR);
  assign accept    = resolve_valid_i && (is_branch || is_jump);

  assign r_idx = resolve_pc_i[IDX_W+1:2];
  assign r_tag = resolve_pc_i[XLEN-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign mispredict_o = accept &&
                        ((resolve_taken_i != resolve_pred_taken_i) ||
                         (resolve_taken_i && resolve_pred_taken_i &&
                          (resolve_target_i != resolve_pred_target_i)));

  assign redirect_pc_o = !mispredict_o   ? '0 :
                         resolve_taken_i ? resolve_target_i :
                                           resolve_pc_i + XLEN'(4);

  // ---------------------------------------------------------------------------
  // Entry update computation
  // ---------------------------------------------------------------------------
  logic                upd_we;
  logic                upd_target_we;
  logic [CNT_BITS-1:0] upd_cnt;

  always_comb begin
    upd_we        = 1'b0;
    upd_target_we = 1'b0;
    upd_cnt       = cnt_q[r_idx];
    if (accept) begin
      if (r_hit) begin
        upd_we = 1'b1;
        if (is_jump) begin
          upd_cnt       = CNT_MAX;
          upd_target_we = 1'b1;
        end else if (resolve_taken_i) begin
          upd_target_we = 1'b1;
          if (cnt_q[r_idx] != CNT_MAX) upd_cnt = cnt_q[r_idx] + CNT_BITS'(1);
        end else begin
          if (cnt_q[r_idx] != CNT_ZERO) upd_cnt = cnt_q[r_idx] - CNT_BITS'(1);
        end
      end else if (resolve_taken_i) begin
        // Allocation replaces whatever occupies the slot.
        upd_we        = 1'b1;
        upd_target_we = 1'b1;
        upd_cnt       = is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  // Reset beats flush, flush beats any same-cycle update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_we) begin
      valid_q[r_idx] <= 1'b1;
      tag_q[r_idx]   <= r_tag;
      cnt_q[r_idx]   <= upd_cnt;
      if (upd_target_we) target_q[r_idx] <= resolve_target_i;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_resolved_q;
  logic [31:0] perf_mispredict_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_resolved_q   <= '0;
      perf_mispredict_q <= '0;
    end else begin
      if (accept)       perf_resolved_q   <= perf_resolved_q + 32'd1;
      if (mispredict_o) perf_mispredict_q <= perf_mispredict_q + 32'd1;
    end
  end

  assign perf_resolved_o   = perf_resolved_q;
  assign perf_mispredict_o = perf_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  localparam logic [6:0] OB = 7'b1100011;
  localparam logic [6:0] OJ = 7'b1101111;
  localparam logic [6:0] OR = 7'b1100111;
  localparam logic [6:0] OX = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic        rv;
  logic [6:0]  op;
  logic [31:0] rpc;
  logic        rtk;
  logic [31:0] rtgt;
  logic        rptk;
  logic [31:0] rptgt;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_resolved;
  logic [31:0] perf_mispredict;
`endif

  int checks = 0;
  int errors = 0;

  branch_predictor_btb #(
    .XLEN(32),
    .ENTRIES(16),
    .CNT_BITS(2)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .F_Pc_i                (f_pc),
    .pred_taken_o          (pred_taken),
    .pred_target_o         (pred_target),
    .flush_i               (flush),
    .resolve_valid_i       (rv),
    .resolve_opcode_i      (op),
    .resolve_pc_i          (rpc),
    .resolve_taken_i       (rtk),
    .resolve_target_i      (rtgt),
    .resolve_pred_taken_i  (rptk),
    .resolve_pred_target_i (rptgt),
    .mispredict_o          (mispredict),
    .redirect_pc_o         (redirect_pc)
`ifdef BRANCH_PERF_CNT_EN
    ,
    .perf_resolved_o       (perf_resolved),
    .perf_mispredict_o     (perf_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] f_pc;
    logic        rv;
    logic [6:0]  op;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_mis;
    logic [31:0] e_red;
    logic        e_pt;
    logic [31:0] e_ptgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic fl, logic [31:0] fp, logic v, logic [6:0] o,
                              logic [31:0] p, logic t, logic [31:0] tg, logic pt,
                              logic [31:0] ptg, logic em, logic [31:0] er, logic ep,
                              logic [31:0] ept);
    vec_t x;
    x.rst = r; x.flush = fl; x.f_pc = fp; x.rv = v; x.op = o; x.pc = p; x.tk = t;
    x.tgt = tg; x.ptk = pt; x.ptgt = ptg; x.e_mis = em; x.e_red = er; x.e_pt = ep;
    x.e_ptgt = ept;
    return x;
  endfunction

  // Lookup-only vector: no resolve, expected prediction for f_pc.
  function automatic vec_t lk(logic [31:0] fp, logic ep, logic [31:0] ept);
    return mk(0, 0, fp, 0, OB, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, ep, ept);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; rv = 0; op = OB; rpc = '0; rtk = 0; rtgt = '0; rptk = 0; rptgt = '0;
  endtask

  task automatic resolve(input logic [6:0] o, input logic [31:0] p, input logic t,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    @(negedge clk);
    idle_inputs();
    rv = 1; op = o; rpc = p; rtk = t; rtgt = tg; rptk = pt; rptgt = ptg;
  endtask

  initial begin
    idle_inputs();
    rst  = 1;
    f_pc = 32'h100;
    repeat (2) @(posedge clk);

    // Directed vectors. Each step: drive after negedge, check mid-phase,
    // then the following posedge commits any update.
    vecs.push_back(lk(32'h100, 0, 32'h0));
    // Taken B allocates weakly taken; same-cycle lookup still sees the miss.
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h80,0,32'h0, 1,32'h80, 0,32'h0));
    vecs.push_back(lk(32'h100, 1, 32'h80));
    // Not-taken twice: 2->1 (mispredict), 1->0, then stays at 0.
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,0,32'h0,1,32'h80, 1,32'h104, 1,32'h80));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0));
    vecs.push_back(lk(32'h100, 0, 32'h0));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h80,0,32'h0, 1,32'h80, 0,32'h0));
    vecs.push_back(lk(32'h100, 0, 32'h0));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h80,0,32'h0, 1,32'h80, 0,32'h0));
    vecs.push_back(lk(32'h100, 1, 32'h80));
    // Correct taken predictions: 2->3, then saturate at 3.
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h80,1,32'h80, 0,32'h0, 1,32'h80));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h80,1,32'h80, 0,32'h0, 1,32'h80));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,0,32'h0,1,32'h80, 1,32'h104, 1,32'h80));
    vecs.push_back(lk(32'h100, 1, 32'h80));
    // Non-control opcode is ignored.
    vecs.push_back(mk(0,0,32'h100,1,OX,32'h100,0,32'h0,1,32'h80, 0,32'h0, 1,32'h80));
    vecs.push_back(lk(32'h100, 1, 32'h80));
    // Taken to a new target (cnt 2->3), then not-taken must keep the target.
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,1,32'h90,1,32'h80, 1,32'h90, 1,32'h80));
    vecs.push_back(lk(32'h100, 1, 32'h90));
    vecs.push_back(mk(0,0,32'h100,1,OB,32'h100,0,32'h777,1,32'h90, 1,32'h104, 1,32'h90));
    vecs.push_back(lk(32'h100, 1, 32'h90));
    // Aliasing: 0x140 shares index 0 with 0x100.
    vecs.push_back(mk(0,0,32'h140,1,OB,32'h140,1,32'h500,0,32'h0, 1,32'h500, 0,32'h0));
    vecs.push_back(lk(32'h100, 0, 32'h0));
    vecs.push_back(lk(32'h140, 1, 32'h500));
    // JALR at 0x200 (index 0 again): allocate, then hit with a new target.
    vecs.push_back(mk(0,0,32'h200,1,OR,32'h200,1,32'h340,1,32'h300, 1,32'h340, 0,32'h0));
    vecs.push_back(lk(32'h200, 1, 32'h340));
    vecs.push_back(lk(32'h140, 0, 32'h0));
    vecs.push_back(mk(0,0,32'h200,1,OR,32'h200,1,32'h380,1,32'h340, 1,32'h380, 1,32'h340));
    vecs.push_back(lk(32'h200, 1, 32'h380));
    // JAL allocates strongly taken: one not-taken still leaves it predicted taken.
    vecs.push_back(mk(0,0,32'h304,1,OJ,32'h304,1,32'h1000,0,32'h0, 1,32'h1000, 0,32'h0));
    vecs.push_back(lk(32'h304, 1, 32'h1000));
    vecs.push_back(mk(0,0,32'h304,1,OB,32'h304,0,32'h0,1,32'h1000, 1,32'h308, 1,32'h1000));
    vecs.push_back(lk(32'h304, 1, 32'h1000));
    // Redirect PC+4 wraps; miss not-taken does not allocate.
    vecs.push_back(mk(0,0,32'hFFFFFFFC,1,OB,32'hFFFFFFFC,0,32'h0,1,32'h10, 1,32'h0, 0,32'h0));
    vecs.push_back(lk(32'hFFFFFFFC, 0, 32'h0));
    vecs.push_back(mk(0,0,32'h008,1,OB,32'h008,0,32'h0,0,32'h0, 0,32'h0, 0,32'h0));
    vecs.push_back(lk(32'h008, 0, 32'h0));
    // Flush with a same-cycle taken resolve: nothing valid afterwards.
    vecs.push_back(mk(0,1,32'h200,1,OB,32'h400,1,32'h404,0,32'h0, 1,32'h404, 1,32'h380));
    vecs.push_back(lk(32'h200, 0, 32'h0));
    vecs.push_back(lk(32'h304, 0, 32'h0));
    vecs.push_back(lk(32'h400, 0, 32'h0));
    // Reset mid-operation discards learned state and a same-cycle update.
    vecs.push_back(mk(0,0,32'h40C,1,OB,32'h40C,1,32'h20,0,32'h0, 1,32'h20, 0,32'h0));
    vecs.push_back(mk(1,0,32'h40C,1,OB,32'h410,1,32'h30,0,32'h0, 1,32'h30, 1,32'h20));
    vecs.push_back(lk(32'h40C, 0, 32'h0));
    vecs.push_back(lk(32'h410, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      flush = vecs[i].flush;
      f_pc  = vecs[i].f_pc;
      rv    = vecs[i].rv;
      op    = vecs[i].op;
      rpc   = vecs[i].pc;
      rtk   = vecs[i].tk;
      rtgt  = vecs[i].tgt;
      rptk  = vecs[i].ptk;
      rptgt = vecs[i].ptgt;
      #1;
      check("mispredict",  i, {31'b0, mispredict}, {31'b0, vecs[i].e_mis});
      check("redirect_pc", i, redirect_pc,         vecs[i].e_red);
      check("pred_taken",  i, {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
      check("pred_target", i, pred_target,         vecs[i].e_ptgt);
    end

    // Hand sequence: back-to-back updates to one entry, each lookup sees
    // only state committed at earlier edges.
    resolve(OB, 32'h50, 1, 32'hA0, 0, 32'h0);
    f_pc = 32'h50; #1;
    check("b2b_pre_alloc", 100, {31'b0, pred_taken}, 32'd0);
    resolve(OB, 32'h50, 0, 32'h0, 1, 32'hA0);
    f_pc = 32'h50; #1;
    check("b2b_after_alloc", 101, pred_target, 32'hA0);
    @(negedge clk);
    idle_inputs();
    f_pc = 32'h50; #1;
    check("b2b_after_dec", 102, {31'b0, pred_taken}, 32'd0);
    check("idle_mispredict", 103, {31'b0, mispredict}, 32'd0);
    check("idle_redirect", 104, redirect_pc, 32'd0);

`ifdef BRANCH_PERF_CNT_EN
    // Perf counters: 5 accepted resolves, 2 of them mispredicting.
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0; #1;
    check("perf_res_reset", 200, perf_resolved, 32'd0);
    check("perf_mis_reset", 201, perf_mispredict, 32'd0);
    resolve(OB, 32'h100, 1, 32'h80, 0, 32'h0);
    resolve(OB, 32'h100, 1, 32'h80, 1, 32'h80);
    resolve(OX, 32'h100, 0, 32'h0, 1, 32'h80);
    resolve(OJ, 32'h304, 1, 32'h1000, 0, 32'h0);
    resolve(OB, 32'h100, 0, 32'h0, 0, 32'h0);
    resolve(OR, 32'h200, 1, 32'h300, 1, 32'h300);
    @(negedge clk);
    idle_inputs();
    flush = 1;
    @(negedge clk);
    idle_inputs(); #1;
    check("perf_resolved", 202, perf_resolved, 32'd5);
    check("perf_mispredict", 203, perf_mispredict, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
